// File: rtl/inst_queue_p2.sv
// Instruction queue: host pushes 12-bit instructions into a FIFO, the head is
// decoded each cycle and either forwarded downstream, turned into a stall, or trapped.
`timescale 1ns/1ps

module inst_queue_p2 #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [11:0]              in_inst,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [11:0]              inst,
    output logic                     inst_en,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     error
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_READY = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      wait_cnt_q, wait_cnt_d;
    logic [11:0]     inst_q, inst_d;
    logic            inst_en_q, inst_en_d;
    logic            error_q, error_d;
    logic            in_ready_q, in_ready_d;

    logic [11:0]     fifo_mem_q [DEPTH];
    logic [11:0]     head;
    logic [3:0]      head_op;
    logic            push;
    logic            pop;
    logic            flush;

    // The head is read combinationally so a word can be consumed on the edge
    // right after it was written.
    assign head    = fifo_mem_q[rd_ptr_q];
    assign head_op = head[11:8];
    assign push    = in_valid && in_ready_q;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        inst_d     = 12'h000;
        inst_en_d  = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;

        case (state_q)
            ST_RESET: state_d = ST_READY;
            ST_READY: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                    case (head_op)
                        4'h0, 4'h1, 4'h2: begin
                            inst_d    = head;
                            inst_en_d = 1'b1;
                        end
                        4'hF: begin
                            // WAIT 0 is just a consumed bubble; no state change.
                            if (head[7:0] != 8'h00) begin
                                wait_cnt_d = head[7:0];
                                state_d    = ST_WAIT;
                            end
                        end
                        default: begin
                            state_d = ST_ERROR;
                            flush   = 1'b1;
                        end
                    endcase
                end
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q - 8'd1;
                if (wait_cnt_q <= 8'd1) begin
                    wait_cnt_d = 8'd0;
                    state_d    = ST_READY;
                end
            end
            ST_ERROR: state_d = ST_ERROR;
            default: begin
                state_d = ST_ERROR;
                flush   = 1'b1;
            end
        endcase

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(push);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            count_d  = count_q + CW'(push) - CW'(pop);
        end

        error_d    = (state_d == ST_ERROR);
        // Accept decision uses post-edge occupancy only, so a full FIFO never
        // accepts even when a pop is happening in the same cycle.
        in_ready_d = ((state_d == ST_READY) || (state_d == ST_WAIT)) &&
                     (count_d < CW'(DEPTH));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_RESET;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wait_cnt_q <= 8'd0;
            inst_q     <= 12'h000;
            inst_en_q  <= 1'b0;
            error_q    <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wait_cnt_q <= wait_cnt_d;
            inst_q     <= inst_d;
            inst_en_q  <= inst_en_d;
            error_q    <= error_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push) begin
            fifo_mem_q[wr_ptr_q] <= in_inst;
        end
    end

    assign in_ready = in_ready_q;
    assign inst     = inst_q;
    assign inst_en  = inst_en_q;
    assign count    = count_q;
    assign error    = error_q;

endmodule
